// File: rtl/spm_arbiter.sv
// rtl/spm_arbiter.sv - three-way SPM access-port arbiter with starvation aging and DMA bursts
//
// Ports:
//   clk, rst_                 clock and synchronous active-high reset
//   mem_*/if_*/dma_*          per-requester req, rw (1=read), addr, wr_data in; gnt, rd_valid out
//   dma_len                   DMA burst length, sampled on the first grant of a burst
//   rd_data                   shared read data, qualified by the *_rd_valid flags
//   spm_as_/rw/addr/wr_data   SPM access strobe (active-low) and command outputs
//   spm_rd_data               SPM read data
//   busy                      high while a DMA burst owns the port

module spm_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int LEN_W        = 5
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_gnt,
    output logic              mem_rd_valid,
    input  logic              if_req,
    input  logic              if_rw,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [DATA_W-1:0] if_wr_data,
    output logic              if_gnt,
    output logic              if_rd_valid,
    input  logic              dma_req,
    input  logic              dma_rw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wr_data,
    input  logic [LEN_W-1:0]  dma_len,
    output logic              dma_gnt,
    output logic              dma_rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [ADDR_W-1:0] spm_addr,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam int                WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    logic [0:0]        state_q,    state_d;
    logic [LEN_W-1:0]  beats_q,    beats_d;
    logic [LEN_W-1:0]  len_q,      len_d;
    logic [WAIT_W-1:0] if_wait_q,  if_wait_d;
    logic [WAIT_W-1:0] dma_wait_q, dma_wait_d;
    logic [2:0]        rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q;

    logic mem_win, if_win, dma_win;
    logic if_starved, dma_starved, in_burst;

    assign if_starved  = (if_wait_q == WAIT_MAX);
    assign dma_starved = (dma_wait_q == WAIT_MAX);
    assign in_burst    = (state_q == ST_BURST);

    // Winner selection. A starved fetch always goes first; a starved DMA
    // only matters outside a burst because its counter is frozen in BURST.
    // Inside a burst the DMA outranks a non-starved fetch.
    always_comb begin
        mem_win = 1'b0;
        if_win  = 1'b0;
        dma_win = 1'b0;
        if (!rst_) begin
            if (if_req && if_starved) begin
                if_win = 1'b1;
            end else if (!in_burst && dma_req && dma_starved) begin
                dma_win = 1'b1;
            end else if (mem_req) begin
                mem_win = 1'b1;
            end else if (in_burst && dma_req) begin
                dma_win = 1'b1;
            end else if (if_req) begin
                if_win = 1'b1;
            end else if (dma_req) begin
                dma_win = 1'b1;
            end
        end
    end

    assign mem_gnt = mem_win;
    assign if_gnt  = if_win;
    assign dma_gnt = dma_win;

    always_comb begin
        spm_as_     = 1'b1;
        spm_rw      = 1'b1;
        spm_addr    = '0;
        spm_wr_data = '0;
        if (mem_win) begin
            spm_as_     = 1'b0;
            spm_rw      = mem_rw;
            spm_addr    = mem_addr;
            spm_wr_data = mem_wr_data;
        end else if (if_win) begin
            spm_as_     = 1'b0;
            spm_rw      = if_rw;
            spm_addr    = if_addr;
            spm_wr_data = if_wr_data;
        end else if (dma_win) begin
            spm_as_     = 1'b0;
            spm_rw      = dma_rw;
            spm_addr    = dma_addr;
            spm_wr_data = dma_wr_data;
        end
    end

    // Aging counters: count denied cycles, saturate at the starvation level.
    always_comb begin
        if_wait_d = if_wait_q;
        if (!if_req || if_win) begin
            if_wait_d = '0;
        end else if (!if_starved) begin
            if_wait_d = if_wait_q + 1'b1;
        end

        dma_wait_d = dma_wait_q;
        if (!dma_req || dma_win) begin
            dma_wait_d = '0;
        end else if (!dma_starved && !in_burst) begin
            dma_wait_d = dma_wait_q + 1'b1;
        end
    end

    // Burst tracking. beats counts granted beats including the first one,
    // so the burst ends on the grant that brings beats up to len.
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (dma_win && (dma_len > LEN_W'(1))) begin
                    state_d = ST_BURST;
                    beats_d = LEN_W'(1);
                    len_d   = dma_len;
                end
            end
            ST_BURST: begin
                if (!dma_req) begin
                    state_d = ST_IDLE;
                    beats_d = '0;
                end else if (dma_win) begin
                    if ((beats_q + 1'b1) == len_q) begin
                        state_d = ST_IDLE;
                        beats_d = '0;
                    end else begin
                        beats_d = beats_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                beats_d = '0;
            end
        endcase
    end

    assign rd_valid_d = {dma_win & dma_rw, if_win & if_rw, mem_win & mem_rw};

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q    <= ST_IDLE;
            beats_q    <= '0;
            len_q      <= '0;
            if_wait_q  <= '0;
            dma_wait_q <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            len_q      <= len_d;
            if_wait_q  <= if_wait_d;
            dma_wait_q <= dma_wait_d;
            rd_valid_q <= rd_valid_d;
            // Only granted reads update the shared data register.
            if (|rd_valid_d) begin
                rd_data_q <= spm_rd_data;
            end
        end
    end

    assign mem_rd_valid = rd_valid_q[0];
    assign if_rd_valid  = rd_valid_q[1];
    assign dma_rd_valid = rd_valid_q[2];
    assign rd_data      = rd_data_q;
    assign busy         = in_burst;

endmodule

// File: tb/tb_spm_arbiter.sv
// tb/tb_spm_arbiter.sv - self-checking bench for spm_arbiter
module tb_spm_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int LIMIT = 8;
    localparam int LW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_;
    logic          mem_req, mem_rw, mem_gnt, mem_rd_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          if_req, if_rw, if_gnt, if_rd_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_wr_data;
    logic          dma_req, dma_rw, dma_gnt, dma_rd_valid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wr_data;
    logic [LW-1:0] dma_len;
    logic [DW-1:0] rd_data;
    logic          spm_as_, spm_rw;
    logic [AW-1:0] spm_addr;
    logic [DW-1:0] spm_wr_data, spm_rd_data;
    logic          busy;

    spm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT), .LEN_W(LW)) dut (
        .clk(clk), .rst_(rst_),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_gnt(mem_gnt), .mem_rd_valid(mem_rd_valid),
        .if_req(if_req), .if_rw(if_rw), .if_addr(if_addr), .if_wr_data(if_wr_data),
        .if_gnt(if_gnt), .if_rd_valid(if_rd_valid),
        .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wr_data(dma_wr_data),
        .dma_len(dma_len), .dma_gnt(dma_gnt), .dma_rd_valid(dma_rd_valid),
        .rd_data(rd_data), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_addr(spm_addr),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data), .busy(busy)
    );

    // SPM environment: asynchronous-read array updated from the DUT's strobes.
    logic [DW-1:0] spm_mem   [0:(1<<AW)-1];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    assign spm_rd_data = spm_mem[spm_addr];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int            m_iw, m_dw, m_beats, m_len;
    bit            m_burst;
    logic [2:0]    m_rdv;
    logic [DW-1:0] m_rdata;

    // Values sampled from the DUT in the most recent cycle.
    logic [2:0]    s_gnt, s_rdv;
    logic [DW-1:0] s_rdata;
    logic          s_busy;

    typedef struct {
        logic          rst;
        logic [2:0]    req;   // {dma, if, mem}
        logic [2:0]    rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [LW-1:0] len;
        logic [2:0]    gnt;
        logic [2:0]    rdv;
        logic [DW-1:0] rdata;
        logic          busy;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester index: 0=mem 1=if 2=dma, -1=nobody.
    function automatic int model_pick();
        bit i_stv, d_stv;
        i_stv = (m_iw >= LIMIT);
        d_stv = (m_dw >= LIMIT);
        if (rst_) return -1;
        if (if_req && i_stv) return 1;
        if (!m_burst && dma_req && d_stv) return 2;
        if (mem_req) return 0;
        if (m_burst && dma_req) return 2;
        if (if_req) return 1;
        if (dma_req) return 2;
        return -1;
    endfunction

    function automatic logic rw_of(input int w);
        return (w == 0) ? mem_rw : (w == 1) ? if_rw : dma_rw;
    endfunction
    function automatic logic [AW-1:0] addr_of(input int w);
        return (w == 0) ? mem_addr : (w == 1) ? if_addr : dma_addr;
    endfunction
    function automatic logic [DW-1:0] wd_of(input int w);
        return (w == 0) ? mem_wr_data : (w == 1) ? if_wr_data : dma_wr_data;
    endfunction

    task automatic model_update(input int w);
        if (rst_) begin
            m_burst = 0; m_beats = 0; m_len = 0; m_iw = 0; m_dw = 0;
            m_rdv = 3'b000; m_rdata = '0;
            return;
        end
        m_rdv = 3'b000;
        if (w >= 0) begin
            if (rw_of(w)) begin
                m_rdv[w] = 1'b1;
                m_rdata  = model_mem[addr_of(w)];
            end else begin
                model_mem[addr_of(w)] = wd_of(w);
            end
        end
        if (!if_req || w == 1) m_iw = 0;
        else if (m_iw < LIMIT) m_iw++;
        if (!dma_req || w == 2) m_dw = 0;
        else if (!m_burst && m_dw < LIMIT) m_dw++;
        if (!m_burst) begin
            if (w == 2 && int'(dma_len) > 1) begin
                m_burst = 1; m_beats = 1; m_len = int'(dma_len);
            end
        end else if (!dma_req) begin
            m_burst = 0;
        end else if (w == 2) begin
            m_beats++;
            if (m_beats == m_len) m_burst = 0;
        end
    endtask

    // One clock: check all outputs against the model, advance through the edge.
    task automatic cycle();
        int            w;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wdat;
        #1;
        w = model_pick();
        chk("mem_gnt", mem_gnt, w == 0);
        chk("if_gnt", if_gnt, w == 1);
        chk("dma_gnt", dma_gnt, w == 2);
        chk("spm_as_", spm_as_, w < 0);
        chk("spm_rw", spm_rw, (w < 0) ? 1'b1 : rw_of(w));
        chk("spm_addr", spm_addr, (w < 0) ? '0 : addr_of(w));
        chk("spm_wr_data", spm_wr_data, (w < 0) ? '0 : wd_of(w));
        chk("mem_rd_valid", mem_rd_valid, m_rdv[0]);
        chk("if_rd_valid", if_rd_valid, m_rdv[1]);
        chk("dma_rd_valid", dma_rd_valid, m_rdv[2]);
        chk("rd_data", rd_data, m_rdata);
        chk("busy", busy, m_burst);
        s_gnt   = {dma_gnt, if_gnt, mem_gnt};
        s_rdv   = {dma_rd_valid, if_rd_valid, mem_rd_valid};
        s_rdata = rd_data;
        s_busy  = busy;
        we   = !spm_as_ && !spm_rw;
        wa   = spm_addr;
        wdat = spm_wr_data;
        @(posedge clk);
        if (we) spm_mem[wa] = wdat;
        model_update(w);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_req = 0; if_req = 0; dma_req = 0;
        mem_rw = 1; if_rw = 1; dma_rw = 1;
        mem_addr = '0; if_addr = '0; dma_addr = '0;
        mem_wr_data = '0; if_wr_data = '0; dma_wr_data = '0;
        dma_len = 5'd1;
    endtask

    initial begin
        int cyc, grants, first_if, mem_before;
        logic [3:0] busy_seen;

        for (int i = 0; i < (1 << AW); i++) begin
            spm_mem[i]   = 32'hC0DE_0000 | i;
            model_mem[i] = 32'hC0DE_0000 | i;
        end
        idle_inputs();
        rst_ = 1'b1;
        m_burst = 0; m_beats = 0; m_len = 0; m_iw = 0; m_dw = 0;
        m_rdv = 3'b000; m_rdata = '0;
        @(posedge clk);
        @(negedge clk);

        //        rst  req     rw      addr    wd          len    gnt     rdv     rdata        busy
        vt[0]  = '{1'b1, 3'b111, 3'b111, 12'd5, 32'h0,     5'd1, 3'b000, 3'b000, 32'h0,       1'b0};
        vt[1]  = '{1'b1, 3'b111, 3'b111, 12'd5, 32'h0,     5'd1, 3'b000, 3'b000, 32'h0,       1'b0};
        vt[2]  = '{1'b0, 3'b000, 3'b000, 12'd5, 32'h0,     5'd1, 3'b000, 3'b000, 32'h0,       1'b0};
        vt[3]  = '{1'b0, 3'b001, 3'b000, 12'd5, 32'hA5,    5'd1, 3'b001, 3'b000, 32'h0,       1'b0};
        vt[4]  = '{1'b0, 3'b010, 3'b010, 12'd5, 32'h0,     5'd1, 3'b010, 3'b000, 32'h0,       1'b0};
        vt[5]  = '{1'b0, 3'b000, 3'b000, 12'd5, 32'h0,     5'd1, 3'b000, 3'b010, 32'hA5,      1'b0};
        vt[6]  = '{1'b0, 3'b001, 3'b001, 12'd5, 32'h0,     5'd1, 3'b001, 3'b000, 32'hA5,      1'b0};
        vt[7]  = '{1'b0, 3'b100, 3'b100, 12'd5, 32'h0,     5'd1, 3'b100, 3'b001, 32'hA5,      1'b0};
        vt[8]  = '{1'b0, 3'b000, 3'b000, 12'd5, 32'h0,     5'd1, 3'b000, 3'b100, 32'hA5,      1'b0};
        vt[9]  = '{1'b0, 3'b011, 3'b011, 12'd5, 32'h0,     5'd1, 3'b001, 3'b000, 32'hA5,      1'b0};
        vt[10] = '{1'b0, 3'b010, 3'b010, 12'd5, 32'h0,     5'd1, 3'b010, 3'b001, 32'hA5,      1'b0};
        vt[11] = '{1'b0, 3'b000, 3'b000, 12'd5, 32'h0,     5'd1, 3'b000, 3'b010, 32'hA5,      1'b0};
        vt[12] = '{1'b1, 3'b001, 3'b001, 12'd5, 32'h0,     5'd1, 3'b000, 3'b000, 32'hA5,      1'b0};
        vt[13] = '{1'b0, 3'b000, 3'b000, 12'd5, 32'h0,     5'd1, 3'b000, 3'b000, 32'h0,       1'b0};

        for (int r = 0; r < 14; r++) begin
            rst_ = vt[r].rst;
            mem_req = vt[r].req[0]; if_req = vt[r].req[1]; dma_req = vt[r].req[2];
            mem_rw  = vt[r].rw[0];  if_rw  = vt[r].rw[1];  dma_rw  = vt[r].rw[2];
            mem_addr = vt[r].addr; if_addr = vt[r].addr; dma_addr = vt[r].addr;
            mem_wr_data = vt[r].wd; if_wr_data = vt[r].wd; dma_wr_data = vt[r].wd;
            dma_len = vt[r].len;
            cycle();
            chk($sformatf("vec%0d_gnt", r), s_gnt, vt[r].gnt);
            chk($sformatf("vec%0d_rdv", r), s_rdv, vt[r].rdv);
            chk($sformatf("vec%0d_rdata", r), s_rdata, vt[r].rdata);
            chk($sformatf("vec%0d_busy", r), s_busy, vt[r].busy);
        end
        idle_inputs();
        rst_ = 1'b0;
        cycle();

        // Starvation: mem holds the port, fetch is promoted after 8 denials.
        mem_req = 1; if_req = 1; dma_req = 1;
        mem_addr = 12'd1; if_addr = 12'd2; dma_addr = 12'd3;
        first_if = 0; mem_before = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (first_if == 0 && s_gnt == 3'b010) first_if = k;
            if (first_if == 0 && s_gnt == 3'b001) mem_before++;
        end
        chk("starve_first_if_cycle", first_if, 9);
        chk("starve_mem_grants_before", mem_before, 8);
        idle_inputs();
        cycle();

        // Plain 4-beat DMA write burst.
        dma_req = 1; dma_rw = 0; dma_len = 5'd4; dma_addr = 12'd0;
        grants = 0; cyc = 0; busy_seen = 4'b0000;
        while (grants < 4 && cyc < 10) begin
            dma_wr_data = 32'd100 + dma_addr;
            cycle();
            cyc++;
            if (s_gnt[2]) begin
                busy_seen[grants] = s_busy;
                grants++;
                dma_addr = dma_addr + 1'b1;
            end
        end
        dma_req = 0;
        chk("burst_cycles", cyc, 4);
        chk("burst_busy_pattern", busy_seen, 4'b1110);
        cycle();
        chk("burst_idle_after", s_busy, 1'b0);
        mem_req = 1; mem_rw = 1; mem_addr = 12'd2;
        cycle();
        idle_inputs();
        cycle();
        chk("burst_readback_rdv", s_rdv, 3'b001);
        chk("burst_readback_data", s_rdata, 32'd102);

        // Burst preempted by a single mem beat; dma_len change is ignored.
        dma_req = 1; dma_rw = 0; dma_len = 5'd4; dma_addr = 12'd16;
        grants = 0; cyc = 0;
        while (grants < 4 && cyc < 10) begin
            mem_req = (cyc == 1); mem_rw = 0; mem_addr = 12'd40; mem_wr_data = 32'd7;
            dma_wr_data = 32'd200 + dma_addr;
            cycle();
            if (cyc == 1) chk("preempt_mem_gnt", s_gnt, 3'b001);
            cyc++;
            if (s_gnt[2]) begin
                grants++;
                dma_addr = dma_addr + 1'b1;
                dma_len = 5'd2;
            end
        end
        chk("preempt_cycles", cyc, 5);
        idle_inputs();
        cycle();

        // Abort by dropping dma_req, then a single-beat DMA access.
        dma_req = 1; dma_rw = 1; dma_len = 5'd8; dma_addr = 12'd0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            dma_addr = dma_addr + 1'b1;
        end
        dma_req = 0;
        cycle();
        chk("abort_still_burst", s_busy, 1'b1);
        cycle();
        chk("abort_idle", s_busy, 1'b0);
        dma_req = 1; dma_len = 5'd1;
        cycle();
        chk("single_dma_gnt", s_gnt, 3'b100);
        dma_req = 0;
        cycle();
        chk("single_no_burst", s_busy, 1'b0);

        // Randomised traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            rst_        = ($urandom_range(0, 99) == 0);
            mem_req     = ($urandom_range(0, 7) != 0) && ($urandom_range(0, 3) != 0);
            if_req      = $urandom_range(0, 1);
            dma_req     = ($urandom_range(0, 3) != 0);
            mem_rw      = $urandom_range(0, 1);
            if_rw       = $urandom_range(0, 1);
            dma_rw      = $urandom_range(0, 1);
            mem_addr    = AW'($urandom_range(0, 15));
            if_addr     = AW'($urandom_range(0, 15));
            dma_addr    = AW'($urandom_range(0, 15));
            mem_wr_data = $urandom;
            if_wr_data  = $urandom;
            dma_wr_data = $urandom;
            dma_len     = LW'($urandom_range(0, 31));
            cycle();
        end
        rst_ = 1'b0;
        idle_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
